i2c_arbiter: RTL and testbench
==============================

I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 Parameter NREQ, default 3: number of requester ports (2..8).
REQ-002 Parameter TMO, default 65535: cycles allowed for the master to drop END after START rises; also the cycles allowed for END to return high.
REQ-003 clk  in  1  sole clock, all logic on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 req  in  NREQ  per-requester transaction request, level, held until its done pulse.
REQ-006 rd  in  NREQ  per-requester: 1 = read transaction, 0 = write.
REQ-007 addr  in  7*NREQ  per-requester 7-bit device address, slice i = bits 7i+6..7i.
REQ-008 wlen  in  NREQ  per-requester: 0 = one write byte, 1 = two write bytes.
REQ-009 wdata  in  16*NREQ  per-requester write bytes, slice i: upper byte = WDATA1, lower byte = WDATA2.
REQ-010 gnt  out  NREQ  one-hot, current owner, or all zero when idle.
REQ-011 done  out  NREQ  one-cycle pulse to the owner at completion.
REQ-012 err  out  1  valid with done: 1 = NACK or timeout.
REQ-013 rdata  out  8  read byte, valid with done; holds until next done.
REQ-014 m_start, m_read, m_addr[6:0], m_wlen, m_wdata1[7:0], m_wdata2[7:0]  out  drive the shared i2c master.
REQ-015 m_end  in  1  master idle/finished (high = idle); m_ack  in  1  master error flag (high = NACK); m_rdata  in  8  master read byte.

Function
REQ-016 States: IDLE, ISSUE, WAIT, DONE; encoding is free.
REQ-017 IDLE: if any req bit is set and m_end = 1, the block grants by round-robin starting from the index after the last owner (index 0 after reset), latches that requester's rd/addr/wlen/wdata into the m_* outputs, sets gnt, asserts m_start, and goes to ISSUE.
REQ-018 IDLE with m_end = 0: the block issues no grant.
REQ-019 ISSUE: m_start stays high until m_end = 0, then the block drops m_start and goes to WAIT. If m_end = 0 is not seen within TMO cycles, the block goes to DONE with err = 1.
REQ-020 WAIT: when m_end = 1, the block captures m_ack into err and m_rdata into rdata (rdata only when m_read = 1) and goes to DONE. If m_end stays low for TMO cycles, the block goes to DONE with err = 1.
REQ-021 DONE: done[owner] pulses for exactly one cycle, gnt clears, the last-owner pointer is updated, m_start = 0, and the block returns to IDLE; a new grant is possible on the next cycle.
REQ-022 Request fields are sampled only at grant; changes to them while granted are ignored.
REQ-023 Deasserting req of the owner mid-transaction does not abort it; done is still pulsed.
REQ-024 Requests arriving during a transaction wait; grant-to-start latency from IDLE is 1 cycle.
REQ-025 The timeout counter is 16 bits wide, saturates, and clears on every state change.
REQ-026 Fairness: with all requests held, each requester gets at most one transaction before every other requester has had one.
REQ-027 At most one gnt bit and at most one done bit are ever high.

Reset
REQ-028 On reset_n = 0, the block immediately sets: state IDLE, gnt = 0, done = 0, err = 0, rdata = 0, m_start = 0, m_read = 0, m_addr = 0, m_wlen = 0, m_wdata1 = 0, m_wdata2 = 0, last-owner pointer = NREQ-1.
REQ-029 Reset during ISSUE or WAIT abandons the transaction without a done pulse; m_start falls asynchronously.
REQ-030 Reset release is synchronised so that the state machine leaves reset on a clk edge.

Verification
REQ-031 Single write: req[0], rd = 0, addr = 0x20, wdata = 0x0900, wlen = 1 -> gnt = 001, m_start high, master model drops m_end after 3 cycles and raises it after 40 cycles with m_ack = 0 -> done[0] pulses once with err = 0.
REQ-032 Read: req[1], rd = 1, model returns m_rdata = 0xA5 -> rdata = 0xA5 with done[1].
REQ-033 Contention: req = 111 held for 6 transactions -> grant order 0, 1, 2, 0, 1, 2.
REQ-034 NACK: model returns m_ack = 1 -> err = 1 with done, and the next requester is granted on the following cycles.
REQ-035 Stuck master: m_end never drops, TMO = 100 -> done with err = 1 at cycle 101 after start, and m_start is low.
REQ-036 Reset asserted mid-WAIT -> all outputs zero with no clk edge needed, no done pulse, and req[0] is granted first after release.

Source files
------------

// File: rtl/i2c_arbiter.sv
// i2c_arbiter
//   Shares one i2c master between NREQ requesters. An idle master (m_end
//   high) is granted round-robin to the next requester after the last
//   owner; that requester's fields are latched onto the m_* bus and
//   m_start is raised until the master goes busy. Completion (master back
//   idle) or a timeout in either phase ends the transaction with a
//   one-cycle done pulse to the owner.
//
// Ports
//   clk, reset_n      clock, asynchronous active-low reset
//   req[NREQ]         level requests, held until done
//   rd, addr, wlen,
//   wdata             per-requester transaction fields (sampled at grant)
//   gnt[NREQ]         one-hot current owner, zero when idle
//   done[NREQ]        one-cycle completion pulse to the owner
//   err, rdata        status and read byte, valid with done (rdata holds)
//   m_start .. m_wdata2  command to the shared master
//   m_end, m_ack, m_rdata  master idle flag, NACK flag, read byte
module i2c_arbiter #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned TMO  = 65535
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        rd,
    input  logic [7*NREQ-1:0]      addr,
    input  logic [NREQ-1:0]        wlen,
    input  logic [16*NREQ-1:0]     wdata,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        done,
    output logic                   err,
    output logic [7:0]             rdata,
    output logic                   m_start,
    output logic                   m_read,
    output logic [6:0]             m_addr,
    output logic                   m_wlen,
    output logic [7:0]             m_wdata1,
    output logic [7:0]             m_wdata2,
    input  logic                   m_end,
    input  logic                   m_ack,
    input  logic [7:0]             m_rdata
);

    localparam int unsigned     PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PW-1:0]   LAST_IDX = PW'(NREQ - 1);
    localparam logic [15:0]     TMO_LAST = 16'(TMO - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state;
    logic [1:0]    rst_sync;
    logic          run;
    logic [PW-1:0] owner;
    logic [PW-1:0] last_ptr;
    logic [15:0]   tmo_cnt;
    logic          tmo_hit;

    logic          pick_valid;
    logic [PW-1:0] pick_idx;
    logic [PW-1:0] cand;
    logic          sel_rd;
    logic          sel_wlen;
    logic [6:0]    sel_addr;
    logic [15:0]   sel_wdata;

    // Reset asserts asynchronously but the FSM only starts running two
    // edges after release, so it always leaves reset on a clean clk edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign run     = rst_sync[1];
    assign tmo_hit = (tmo_cnt >= TMO_LAST);

    // Round-robin: scan from the index after the last owner, wrapping.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = PW'((32'(last_ptr) + k) % NREQ);
            if (!pick_valid && req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        sel_rd    = 1'b0;
        sel_wlen  = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick_idx == PW'(i)) begin
                sel_rd    = rd[i];
                sel_wlen  = wlen[i];
                sel_addr  = addr[7*i +: 7];
                sel_wdata = wdata[16*i +: 16];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            gnt      <= '0;
            done     <= '0;
            err      <= 1'b0;
            rdata    <= '0;
            m_start  <= 1'b0;
            m_read   <= 1'b0;
            m_addr   <= '0;
            m_wlen   <= 1'b0;
            m_wdata1 <= '0;
            m_wdata2 <= '0;
            owner    <= '0;
            last_ptr <= LAST_IDX;
            tmo_cnt  <= '0;
        end else if (run) begin
            case (state)
                S_IDLE: begin
                    if (pick_valid && m_end) begin
                        owner           <= pick_idx;
                        gnt             <= '0;
                        gnt[pick_idx]   <= 1'b1;
                        m_read          <= sel_rd;
                        m_addr          <= sel_addr;
                        m_wlen          <= sel_wlen;
                        m_wdata1        <= sel_wdata[15:8];
                        m_wdata2        <= sel_wdata[7:0];
                        m_start         <= 1'b1;
                        tmo_cnt         <= '0;
                        state           <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!m_end) begin
                        m_start <= 1'b0;
                        tmo_cnt <= '0;
                        state   <= S_WAIT;
                    end else if (tmo_hit) begin
                        m_start     <= 1'b0;
                        err         <= 1'b1;
                        done[owner] <= 1'b1;
                        tmo_cnt     <= '0;
                        state       <= S_DONE;
                    end else if (tmo_cnt != '1) begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                S_WAIT: begin
                    if (m_end) begin
                        err         <= m_ack;
                        if (m_read) begin
                            rdata <= m_rdata;
                        end
                        done[owner] <= 1'b1;
                        tmo_cnt     <= '0;
                        state       <= S_DONE;
                    end else if (tmo_hit) begin
                        err         <= 1'b1;
                        done[owner] <= 1'b1;
                        tmo_cnt     <= '0;
                        state       <= S_DONE;
                    end else if (tmo_cnt != '1) begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                S_DONE: begin
                    done     <= '0;
                    gnt      <= '0;
                    last_ptr <= owner;
                    tmo_cnt  <= '0;
                    state    <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_arbiter.sv
// Bench for i2c_arbiter (NREQ=3, TMO=100): directed transactions against a
// bus-functional master, with a transaction-rule model checked every cycle.
module tb_i2c_arbiter;

    localparam int N     = 3;
    localparam int TMO_B = 100;

    localparam int PH_IDLE  = 0;
    localparam int PH_ISSUE = 1;
    localparam int PH_WAIT  = 2;
    localparam int PH_DONE  = 3;

    localparam int MM_NORMAL = 0;
    localparam int MM_STUCK  = 1;
    localparam int MM_HANG   = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [N-1:0]  req;
    logic [N-1:0]  rd;
    logic [7*N-1:0]  addr;
    logic [N-1:0]  wlen;
    logic [16*N-1:0] wdata;
    logic [N-1:0]  gnt;
    logic [N-1:0]  done;
    logic          err;
    logic [7:0]    rdata;
    logic          m_start;
    logic          m_read;
    logic [6:0]    m_addr;
    logic          m_wlen;
    logic [7:0]    m_wdata1;
    logic [7:0]    m_wdata2;
    logic          m_end;
    logic          m_ack;
    logic [7:0]    m_rdata;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    i2c_arbiter #(.NREQ(N), .TMO(TMO_B)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .rd       (rd),
        .addr     (addr),
        .wlen     (wlen),
        .wdata    (wdata),
        .gnt      (gnt),
        .done     (done),
        .err      (err),
        .rdata    (rdata),
        .m_start  (m_start),
        .m_read   (m_read),
        .m_addr   (m_addr),
        .m_wlen   (m_wlen),
        .m_wdata1 (m_wdata1),
        .m_wdata2 (m_wdata2),
        .m_end    (m_end),
        .m_ack    (m_ack),
        .m_rdata  (m_rdata)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- bus-functional master ----------------
    int mm_mode  = MM_NORMAL;
    int mm_drop  = 3;
    int mm_busy  = 40;
    logic       mm_ack   = 1'b0;
    logic [7:0] mm_rdata = 8'h00;

    initial begin
        int ms;
        int mcnt;
        ms = 0;
        mcnt = 0;
        m_end = 1'b1;
        m_ack = 1'b0;
        m_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                ms = 0;
                m_end = 1'b1;
            end else begin
                case (ms)
                    0: if (m_start && mm_mode != MM_STUCK) begin
                        ms = 1;
                        mcnt = 0;
                    end
                    1: begin
                        mcnt++;
                        if (mcnt == mm_drop) begin
                            m_end = 1'b0;
                            ms = 2;
                            mcnt = 0;
                        end
                    end
                    default: if (mm_mode != MM_HANG) begin
                        mcnt++;
                        if (mcnt == mm_busy) begin
                            m_end = 1'b1;
                            m_ack = mm_ack;
                            m_rdata = mm_rdata;
                            ms = 0;
                        end
                    end
                endcase
            end
        end
    end

    // ---------------- reference model ----------------
    int         mph = PH_IDLE;
    int         mk = 0;
    int         mowner = 0;
    int         mptr = N - 1;
    int         mrel = 0;
    logic [N-1:0] exp_gnt = '0;
    logic [N-1:0] exp_done = '0;
    logic       exp_err = 1'b0;
    logic [7:0] exp_rdata = '0;
    logic       exp_mstart = 1'b0;
    logic       exp_mread = 1'b0;
    logic [6:0] exp_maddr = '0;
    logic       exp_mwlen = 1'b0;
    logic [7:0] exp_w1 = '0;
    logic [7:0] exp_w2 = '0;

    function automatic int rr_pick(input int ptr, input logic [N-1:0] r);
        for (int d = 1; d <= N; d++) begin
            if (r[(ptr + d) % N]) return (ptr + d) % N;
        end
        return -1;
    endfunction

    task automatic finish_txn(input logic e);
        mph = PH_DONE;
        exp_mstart = 1'b0;
        exp_err = e;
        exp_done = '0;
        exp_done[mowner] = 1'b1;
    endtask

    // Advance the model by one clock edge using the inputs the DUT sampled.
    task automatic model_step();
        int c;
        if (!reset_n) begin
            mph = PH_IDLE; mk = 0; mowner = 0; mptr = N - 1; mrel = 0;
            exp_gnt = '0; exp_done = '0; exp_err = 1'b0; exp_rdata = '0;
            exp_mstart = 1'b0; exp_mread = 1'b0; exp_maddr = '0;
            exp_mwlen = 1'b0; exp_w1 = '0; exp_w2 = '0;
        end else begin
            if (mrel < 3) mrel++;
            exp_done = '0;
            case (mph)
                PH_IDLE: if (mrel >= 3 && req != '0 && m_end) begin
                    c = rr_pick(mptr, req);
                    mowner = c;
                    exp_gnt = '0;
                    exp_gnt[c] = 1'b1;
                    exp_mstart = 1'b1;
                    exp_mread = rd[c];
                    exp_maddr = addr[7*c +: 7];
                    exp_mwlen = wlen[c];
                    exp_w1 = wdata[16*c+8 +: 8];
                    exp_w2 = wdata[16*c +: 8];
                    mph = PH_ISSUE;
                    mk = 0;
                end
                PH_ISSUE: begin
                    mk++;
                    if (!m_end) begin
                        mph = PH_WAIT;
                        mk = 0;
                        exp_mstart = 1'b0;
                    end else if (mk == TMO_B) begin
                        finish_txn(1'b1);
                    end
                end
                PH_WAIT: begin
                    mk++;
                    if (m_end) begin
                        if (exp_mread) exp_rdata = m_rdata;
                        finish_txn(m_ack);
                    end else if (mk == TMO_B) begin
                        finish_txn(1'b1);
                    end
                end
                default: begin
                    exp_gnt = '0;
                    mptr = mowner;
                    mph = PH_IDLE;
                end
            endcase
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        model_step();
        chk("gnt_onehot", 32'($countones(gnt) <= 1), 1);
        chk("done_onehot", 32'($countones(done) <= 1), 1);
        chk("gnt", gnt, exp_gnt);
        chk("done", done, exp_done);
        if (exp_done != '0) chk("err", err, exp_err);
        chk("rdata", rdata, exp_rdata);
        chk("m_start", m_start, exp_mstart);
        chk("m_read", m_read, exp_mread);
        chk("m_addr", m_addr, exp_maddr);
        chk("m_wlen", m_wlen, exp_mwlen);
        chk("m_wdata1", m_wdata1, exp_w1);
        chk("m_wdata2", m_wdata2, exp_w2);
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_gnt(input string nm, input logic [N-1:0] exp, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (gnt == '0 && n < budget);
        chk(nm, gnt, exp);
    endtask

    task automatic wait_done(input string nm, input int budget, output logic [N-1:0] dm);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done == '0 && n < budget);
        chk({nm, "_seen"}, 32'(done != '0), 1);
        dm = done;
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_gnt"}, gnt, 0);
        chk({nm, "_done"}, done, 0);
        chk({nm, "_err"}, err, 0);
        chk({nm, "_rdata"}, rdata, 0);
        chk({nm, "_m_start"}, m_start, 0);
        chk({nm, "_m_read"}, m_read, 0);
        chk({nm, "_m_addr"}, m_addr, 0);
        chk({nm, "_m_wlen"}, m_wlen, 0);
        chk({nm, "_m_wdata"}, {m_wdata1, m_wdata2}, 0);
    endtask

    initial begin
        logic [N-1:0] dm;
        int order_q[$];
        int exp_order[6];
        int g;
        int n;
        exp_order = '{0, 1, 2, 0, 1, 2};

        reset_n = 1'b0;
        req = '0; rd = '0; addr = '0; wlen = '0; wdata = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // single two-byte write from requester 0; fields and req change mid-flight
        addr[6:0] = 7'h20; wdata[15:0] = 16'h0900; wlen[0] = 1'b1; rd[0] = 1'b0;
        req = 3'b001;
        wait_gnt("wr_gnt", 3'b001, 10);
        chk("wr_m_start", m_start, 1);
        chk("wr_m_addr", m_addr, 7'h20);
        chk("wr_m_wdata", {m_wdata1, m_wdata2}, 16'h0900);
        chk("wr_m_wlen", m_wlen, 1);
        addr[6:0] = 7'h33; wdata[15:0] = 16'hFFFF;
        req = 3'b000;
        wait_done("wr_done", 300, dm);
        chk("wr_done_mask", dm, 3'b001);
        chk("wr_err", err, 0);

        // read from requester 1
        rd[1] = 1'b1; addr[13:7] = 7'h51; mm_rdata = 8'hA5;
        req = 3'b010;
        wait_gnt("rd_gnt", 3'b010, 10);
        chk("rd_m_read", m_read, 1);
        wait_done("rd_done", 300, dm);
        req = 3'b000;
        chk("rd_done_mask", dm, 3'b010);
        chk("rd_rdata", rdata, 8'hA5);
        chk("rd_err", err, 0);

        // NACK on requester 2, then everyone contends
        mm_ack = 1'b1; mm_busy = 5;
        addr[20:14] = 7'h6E; wdata[47:32] = 16'h1234;
        req = 3'b100;
        wait_gnt("nack_gnt", 3'b100, 10);
        req = 3'b111;
        wait_done("nack_done", 100, dm);
        chk("nack_done_mask", dm, 3'b100);
        chk("nack_err", err, 1);
        mm_ack = 1'b0;
        wait_gnt("nack_next_gnt", 3'b001, 4);
        for (int t = 0; t < 6; t++) begin
            wait_done("rr_done", 100, dm);
            for (int i = 0; i < N; i++) if (dm[i]) order_q.push_back(i);
        end
        req = 3'b000;
        chk("rr_count", order_q.size(), 6);
        for (int t = 0; t < 6 && t < order_q.size(); t++) chk("rr_order", order_q[t], exp_order[t]);

        // master never goes busy: ISSUE timeout
        mm_mode = MM_STUCK;
        req = 3'b001;
        wait_gnt("stuck_gnt", 3'b001, 10);
        g = cyc;
        wait_done("stuck_done", 200, dm);
        chk("stuck_cycle", cyc - g + 1, 101);
        chk("stuck_err", err, 1);
        chk("stuck_m_start", m_start, 0);
        req = 3'b000;
        mm_mode = MM_NORMAL;

        // master goes busy but never returns: WAIT timeout, then no grant while busy
        mm_mode = MM_HANG;
        req = 3'b010;
        wait_gnt("hang_gnt", 3'b010, 10);
        wait_done("hang_done", 300, dm);
        req = 3'b000;
        chk("hang_done_mask", dm, 3'b010);
        chk("hang_err", err, 1);
        req = 3'b001;
        repeat (8) @(negedge clk);
        chk("busy_no_gnt", gnt, 0);
        mm_mode = MM_NORMAL;
        wait_gnt("recover_gnt", 3'b001, 20);
        wait_done("recover_done", 100, dm);
        req = 3'b000;
        chk("recover_err", err, 0);

        // reset while the master is busy
        mm_mode = MM_HANG;
        req = 3'b010;
        wait_gnt("rst_gnt", 3'b010, 10);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (m_start && n < 20);
        chk("rst_in_wait", m_start, 0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check_zero("async_rst");
        mm_mode = MM_NORMAL;
        req = 3'b011;
        repeat (3) @(negedge clk);
        check_zero("held_rst");
        reset_n = 1'b1;
        wait_gnt("post_rst_gnt", 3'b001, 10);
        wait_done("post_rst_done", 100, dm);
        req = 3'b000;
        chk("post_rst_mask", dm, 3'b001);
        repeat (5) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
